// File: rtl/sample_buffer_framer_if.sv
// AXI-stream style bundle (data/valid/ready/last) shared by the framer's input and output.
interface Axis_If #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sample_buffer_framer.sv
// Strips the channel/count header words from the sample_buffer readout stream and emits
// one AXI-stream packet per bank, with the bank's channel index travelling as a sideband.
module sample_buffer_framer #(
    parameter int N_CHANNELS       = 8,
    parameter int BUFFER_DEPTH     = 1024,
    parameter int PARALLEL_SAMPLES = 1,
    parameter int SAMPLE_WIDTH     = 16,
    localparam int DWIDTH          = PARALLEL_SAMPLES * SAMPLE_WIDTH,
    localparam int CH_BITS         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int RW              = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    Axis_If.slave              data_in,
    Axis_If.master             data_out,
    output logic [CH_BITS-1:0] channel_out,
    output logic [15:0]        frame_count,
    output logic [15:0]        empty_banks,
    output logic               hdr_error,
    input  logic               clear_errors,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        CHAN  = 2'd0,
        COUNT = 2'd1,
        DATA  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DWIDTH-1:0]  data;
        logic               last;
        logic [CH_BITS-1:0] ch;
    } beat_t;

    // Handshake: a word moves on a rising edge where valid && ready; valid never waits on ready.
    state_t             state_q, state_d;
    logic [CH_BITS-1:0] ch_q, ch_d;
    logic [RW-1:0]      rem_q, rem_d;
    beat_t              head_q, head_d;
    beat_t              skid_q, skid_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [15:0]        frame_q, frame_d;
    logic [15:0]        empty_q, empty_d;
    logic               err_q, err_d;

    logic [31:0] word32;
    logic        in_ready;
    logic        in_hs;
    logic        push;
    logic        pop;
    beat_t       new_beat;

    assign word32 = 32'(data_in.data);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        rem_d    = rem_q;
        frame_d  = frame_q;
        empty_d  = clear_errors ? 16'd0 : empty_q;
        err_d    = clear_errors ? 1'b0 : err_q;
        push     = 1'b0;
        new_beat = '{data: data_in.data, last: (rem_q == RW'(1)), ch: ch_q};

        case (state_q)
            CHAN:    in_ready = 1'b1;
            COUNT:   in_ready = 1'b1;
            DATA:    in_ready = (cnt_q != 2'd2);
            default: in_ready = 1'b0;
        endcase
        in_hs = in_ready && reset_n && data_in.valid;

        // An error event in the same cycle as clear_errors overrides the clear.
        case (state_q)
            CHAN: begin
                if (in_hs) begin
                    ch_d    = data_in.data[CH_BITS-1:0];
                    state_d = COUNT;
                    if (word32 >= 32'(N_CHANNELS)) err_d = 1'b1;
                end
            end
            COUNT: begin
                if (in_hs) begin
                    if (word32 == 32'd0) begin
                        if (empty_d != 16'hFFFF) empty_d = empty_d + 16'd1;
                        state_d = CHAN;
                    end else if (word32 > 32'(BUFFER_DEPTH)) begin
                        err_d   = 1'b1;
                        rem_d   = RW'(BUFFER_DEPTH);
                        state_d = DATA;
                    end else begin
                        rem_d   = RW'(word32);
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (in_hs) begin
                    push  = 1'b1;
                    rem_d = rem_q - RW'(1);
                    if (rem_q == RW'(1)) begin
                        frame_d = frame_q + 16'd1;
                        state_d = CHAN;
                    end
                end
            end
            default: state_d = CHAN;
        endcase
    end

    // Two-entry output queue: head_q drives the outputs, skid_q catches a word while stalled.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        pop    = (cnt_q != 2'd0) && data_out.ready;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = new_beat;
                else               skid_d = new_beat;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = skid_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = new_beat;
                end else begin
                    head_d = skid_q;
                    skid_d = new_beat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CHAN;
            ch_q    <= '0;
            rem_q   <= '0;
            head_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= 2'd0;
            frame_q <= 16'd0;
            empty_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign data_in.ready  = in_ready && reset_n;
    assign data_out.data  = head_q.data;
    assign data_out.last  = head_q.last;
    assign data_out.valid = (cnt_q != 2'd0);
    assign channel_out    = head_q.ch;
    assign frame_count    = frame_q;
    assign empty_banks    = empty_q;
    assign hdr_error      = err_q;
    assign dbg_state      = state_q;

endmodule
